// File: rtl/intr_ctrl_if.sv
// intr_ctrl_if: interrupt handshake between intr_ctrl and the CU FSM.
//   intr       - interrupt request from the controller
//   cause_id   - index of the source being requested or serviced
//   in_service - a handler is running and no new request will be raised
//   int_taken  - CU is in its interrupt state (acknowledge), 1-cycle pulse
//   mret_exec  - CU is executing mret, 1-cycle pulse
// Modports: master = interrupt controller, slave = CU FSM.
interface intr_ctrl_if #(
  parameter int NUM_SRC = 4
);
  localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic            intr;
  logic [ID_W-1:0] cause_id;
  logic            in_service;
  logic            int_taken;
  logic            mret_exec;

  modport master (
    output intr, cause_id, in_service,
    input  int_taken, mret_exec
  );

  modport slave (
    input  intr, cause_id, in_service,
    output int_taken, mret_exec
  );
endinterface

// File: rtl/intr_ctrl.sv
// intr_ctrl: interrupt controller for the multicycle OTTER CU FSM.
// Synchronizes the external lines and detects rising edges. Each edge latches
// a pending bit. The lowest-index pending, enabled source (gated by gie) is
// presented to the CU as a single registered request. The controller then
// tracks the acknowledge and the mret.
// Ports:
//   clk, RST_N  - system clock, asynchronous active-low reset
//   src         - raw asynchronous interrupt lines (rising-edge triggered)
//   src_en      - per-source enable mask
//   gie         - global interrupt enable
//   pending     - pending event bits (register output)
//   cu          - intr_ctrl_if.master handshake to the CU FSM
// Optional build macro INTR_OVERRUN_CNT_EN adds:
//   ovr_clr     - synchronous clear of the overrun counter
//   ovr_cnt     - saturating count of edges absorbed by an already-set pending bit
//
// state   | meaning
// IDLE    | no request outstanding; a new request is raised when the eligible set is nonzero
// REQ     | intr held high with cause_id frozen until int_taken
// SERVICE | handler running; waiting for mret_exec
module intr_ctrl #(
  parameter int NUM_SRC     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               RST_N,
  input  logic [NUM_SRC-1:0] src,
  input  logic [NUM_SRC-1:0] src_en,
  input  logic               gie,
  output logic [NUM_SRC-1:0] pending,
  intr_ctrl_if.master        cu
`ifdef INTR_OVERRUN_CNT_EN
  ,
  input  logic               ovr_clr,
  output logic [7:0]         ovr_cnt
`endif
);
  localparam int ID_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  // One-hot encoding, so intr and in_service are single flop bits.
  typedef enum logic [2:0] {
    IDLE    = 3'b001,
    REQ     = 3'b010,
    SERVICE = 3'b100
  } state_t;

  state_t              state_q, state_d;
  logic [NUM_SRC-1:0]  sync_q [SYNC_STAGES];
  logic [NUM_SRC-1:0]  prev_q;
  logic [NUM_SRC-1:0]  edge_det;
  logic [NUM_SRC-1:0]  pending_q;
  logic [NUM_SRC-1:0]  eligible;
  logic [NUM_SRC-1:0]  clr_mask;
  logic [ID_W-1:0]     cause_q;
  logic [ID_W-1:0]     winner;
  logic                ack;

  // Synchronizer chain plus edge history
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      prev_q <= '0;
    end else begin
      sync_q[0] <= src;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edge_det = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign ack      = (state_q == REQ) && cu.int_taken;
  assign clr_mask = ack ? (NUM_SRC'(1) << cause_q) : '0;
  assign eligible = gie ? (pending_q & src_en) : '0;

  // Clear first, then OR in the set, so a coinciding edge keeps the bit at 1.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) pending_q <= '0;
    else        pending_q <= (pending_q & ~clr_mask) | edge_det;
  end

  // Scan from the top index down so that the lowest eligible index is written last.
  always_comb begin
    winner = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) winner = ID_W'(i);
    end
  end

  // State register and the cause register it governs
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cause_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && |eligible) cause_q <= winner;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|eligible) state_d = REQ;
      REQ:     if (cu.int_taken) state_d = SERVICE;
      SERVICE: if (cu.mret_exec) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: each output is a direct flop bit.
  always_comb begin
    cu.intr       = state_q[1];
    cu.in_service = state_q[2];
    cu.cause_id   = cause_q;
    pending       = pending_q;
  end

`ifdef INTR_OVERRUN_CNT_EN
  // An edge on a bit that is already set is an overrun. The bit being cleared
  // this cycle is still set, so the edge-meets-clear case is included too.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N)                                        ovr_cnt <= '0;
    else if (ovr_clr)                                  ovr_cnt <= '0;
    else if (|(edge_det & pending_q) && ovr_cnt != 8'hFF) ovr_cnt <= ovr_cnt + 8'd1;
  end
`endif
endmodule

// File: tb/tb_intr_ctrl.sv
module tb_intr_ctrl;
  logic       clk;
  logic       RST_N;
  logic [3:0] src;
  logic [3:0] src_en;
  logic       gie;
  logic [3:0] pending;
`ifdef INTR_OVERRUN_CNT_EN
  logic       ovr_clr;
  logic [7:0] ovr_cnt;
`endif

  int errors = 0;
  int checks = 0;

  intr_ctrl_if #(.NUM_SRC(4)) cu_if ();

  intr_ctrl #(.NUM_SRC(4), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .RST_N   (RST_N),
    .src     (src),
    .src_en  (src_en),
    .gie     (gie),
    .pending (pending),
    .cu      (cu_if)
`ifdef INTR_OVERRUN_CNT_EN
    ,
    .ovr_clr (ovr_clr),
    .ovr_cnt (ovr_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge; inputs change and outputs are sampled 1 time unit later.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    RST_N = 1'b0; src = 4'b0000; src_en = 4'hF; gie = 1'b1;
    cu_if.int_taken = 1'b0; cu_if.mret_exec = 1'b0;
`ifdef INTR_OVERRUN_CNT_EN
    ovr_clr = 1'b0;
`endif
    step(3);
    checks++; if (cu_if.intr !== 1'b0) begin errors++; $display("FAIL reset_intr: got %b want 0", cu_if.intr); end
    checks++; if (cu_if.in_service !== 1'b0) begin errors++; $display("FAIL reset_in_service: got %b want 0", cu_if.in_service); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL reset_pending: got %b want 0000", pending); end
    checks++; if (cu_if.cause_id !== 2'd0) begin errors++; $display("FAIL reset_cause: got %0d want 0", cu_if.cause_id); end
`ifdef INTR_OVERRUN_CNT_EN
    checks++; if (ovr_cnt !== 8'd0) begin errors++; $display("FAIL reset_ovr_cnt: got %0d want 0", ovr_cnt); end
`endif
    RST_N = 1'b1;
    step(2);
  endtask

  task automatic test_edge_latency();
    src = 4'b0100;   // rises before edge k
    step(1);         // edge k
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL lat_k: got %b want 0000", pending); end
    step(1);         // edge k+1
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL lat_k1: got %b want 0000", pending); end
    step(1);         // edge k+2
    checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL lat_k2_pending: got %b want 0100", pending); end
    checks++; if (cu_if.intr !== 1'b0) begin errors++; $display("FAIL lat_k2_intr: got %b want 0", cu_if.intr); end
    step(1);         // edge k+3
    checks++; if (cu_if.intr !== 1'b1) begin errors++; $display("FAIL lat_k3_intr: got %b want 1", cu_if.intr); end
    checks++; if (cu_if.cause_id !== 2'd2) begin errors++; $display("FAIL lat_k3_cause: got %0d want 2", cu_if.cause_id); end
    step(1);
    checks++; if (cu_if.intr !== 1'b1) begin errors++; $display("FAIL req_hold: got %b want 1", cu_if.intr); end
  endtask

  task automatic test_ack_mret();
    cu_if.int_taken = 1'b1; step(1); cu_if.int_taken = 1'b0;
    checks++; if (cu_if.intr !== 1'b0) begin errors++; $display("FAIL ack_intr: got %b want 0", cu_if.intr); end
    checks++; if (cu_if.in_service !== 1'b1) begin errors++; $display("FAIL ack_in_service: got %b want 1", cu_if.in_service); end
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL ack_pending: got %b want 0000", pending); end
    checks++; if (cu_if.cause_id !== 2'd2) begin errors++; $display("FAIL svc_cause: got %0d want 2", cu_if.cause_id); end
    src = 4'b0000;
    cu_if.mret_exec = 1'b1; step(1); cu_if.mret_exec = 1'b0;
    checks++; if (cu_if.in_service !== 1'b0) begin errors++; $display("FAIL mret_in_service: got %b want 0", cu_if.in_service); end
    step(3);
    checks++; if (cu_if.intr !== 1'b0) begin errors++; $display("FAIL mret_intr: got %b want 0", cu_if.intr); end
  endtask

  task automatic test_priority();
    src = 4'b1010;
    step(3);
    checks++; if (pending !== 4'b1010) begin errors++; $display("FAIL prio_pending: got %b want 1010", pending); end
    step(1);
    checks++; if (cu_if.intr !== 1'b1 || cu_if.cause_id !== 2'd1) begin errors++; $display("FAIL prio_first: got intr=%b cause=%0d want intr=1 cause=1", cu_if.intr, cu_if.cause_id); end
    cu_if.int_taken = 1'b1; step(1); cu_if.int_taken = 1'b0;
    checks++; if (pending !== 4'b1000) begin errors++; $display("FAIL prio_clear1: got %b want 1000", pending); end
    cu_if.mret_exec = 1'b1; step(1); cu_if.mret_exec = 1'b0;
    checks++; if (cu_if.intr !== 1'b0 || cu_if.in_service !== 1'b0) begin errors++; $display("FAIL prio_idle_gap: got intr=%b in_service=%b want 0 0", cu_if.intr, cu_if.in_service); end
    step(1);
    checks++; if (cu_if.intr !== 1'b1 || cu_if.cause_id !== 2'd3) begin errors++; $display("FAIL prio_second: got intr=%b cause=%0d want intr=1 cause=3", cu_if.intr, cu_if.cause_id); end
    // int_taken and mret_exec together in REQ: only the acknowledge counts
    cu_if.int_taken = 1'b1; cu_if.mret_exec = 1'b1; step(1);
    cu_if.int_taken = 1'b0; cu_if.mret_exec = 1'b0;
    checks++; if (cu_if.in_service !== 1'b1 || pending !== 4'b0000) begin errors++; $display("FAIL both_pulses: got in_service=%b pending=%b want 1 0000", cu_if.in_service, pending); end
    step(1);
    checks++; if (cu_if.in_service !== 1'b1) begin errors++; $display("FAIL both_hold: got %b want 1", cu_if.in_service); end
    cu_if.mret_exec = 1'b1; step(1); cu_if.mret_exec = 1'b0;
    checks++; if (cu_if.in_service !== 1'b0) begin errors++; $display("FAIL prio_mret2: got %b want 0", cu_if.in_service); end
    src = 4'b0000;
    step(3);
  endtask

  task automatic test_gie();
    gie = 1'b0; src = 4'b0001;
    step(3);
    checks++; if (pending !== 4'b0001) begin errors++; $display("FAIL gie_pending: got %b want 0001", pending); end
    step(2);
    checks++; if (cu_if.intr !== 1'b0) begin errors++; $display("FAIL gie_blocked: got %b want 0", cu_if.intr); end
    gie = 1'b1; step(1);
    checks++; if (cu_if.intr !== 1'b1 || cu_if.cause_id !== 2'd0) begin errors++; $display("FAIL gie_request: got intr=%b cause=%0d want intr=1 cause=0", cu_if.intr, cu_if.cause_id); end
    gie = 1'b0; src_en = 4'h0; step(2);
    checks++; if (cu_if.intr !== 1'b1) begin errors++; $display("FAIL no_withdraw: got %b want 1", cu_if.intr); end
    cu_if.int_taken = 1'b1; step(1); cu_if.int_taken = 1'b0;
    checks++; if (cu_if.in_service !== 1'b1 || pending !== 4'b0000) begin errors++; $display("FAIL gie_ack: got in_service=%b pending=%b want 1 0000", cu_if.in_service, pending); end
    cu_if.mret_exec = 1'b1; step(1); cu_if.mret_exec = 1'b0;
    src = 4'b0000; src_en = 4'hF; gie = 1'b1;
    step(3);
  endtask

  task automatic test_mask_and_async_reset();
    src_en = 4'b1101; src = 4'b0010;
    step(4);
    checks++; if (pending !== 4'b0010 || cu_if.intr !== 1'b0) begin errors++; $display("FAIL mask: got pending=%b intr=%b want 0010 0", pending, cu_if.intr); end
    src_en = 4'hF; step(1);
    checks++; if (cu_if.intr !== 1'b1 || cu_if.cause_id !== 2'd1) begin errors++; $display("FAIL unmask: got intr=%b cause=%0d want intr=1 cause=1", cu_if.intr, cu_if.cause_id); end
    #3;
    src = 4'b0000;
    RST_N = 1'b0;
    #1;
    checks++; if (cu_if.intr !== 1'b0 || pending !== 4'b0000 || cu_if.in_service !== 1'b0) begin errors++; $display("FAIL async_reset: got intr=%b pending=%b in_service=%b want 0 0000 0", cu_if.intr, pending, cu_if.in_service); end
    step(1);
    RST_N = 1'b1;
    step(3);
    cu_if.int_taken = 1'b1; step(1); cu_if.int_taken = 1'b0;
    checks++; if (cu_if.intr !== 1'b0 || cu_if.in_service !== 1'b0) begin errors++; $display("FAIL idle_int_taken: got intr=%b in_service=%b want 0 0", cu_if.intr, cu_if.in_service); end
    cu_if.mret_exec = 1'b1; step(1); cu_if.mret_exec = 1'b0;
    checks++; if (cu_if.intr !== 1'b0 || cu_if.in_service !== 1'b0) begin errors++; $display("FAIL idle_mret: got intr=%b in_service=%b want 0 0", cu_if.intr, cu_if.in_service); end
  endtask

`ifdef INTR_OVERRUN_CNT_EN
  task automatic test_overrun();
    gie = 1'b0;
    // first pulse sets pending[1], the following three are overruns
    for (int i = 0; i < 4; i++) begin
      src = 4'b0010; step(1);
      src = 4'b0000; step(1);
    end
    step(3);
    checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL ovr_pending: got %b want 0010", pending); end
    checks++; if (ovr_cnt !== 8'd3) begin errors++; $display("FAIL ovr_three: got %0d want 3", ovr_cnt); end
    for (int i = 0; i < 300; i++) begin
      src = 4'b0010; step(1);
      src = 4'b0000; step(1);
    end
    step(3);
    checks++; if (ovr_cnt !== 8'd255) begin errors++; $display("FAIL ovr_saturate: got %0d want 255", ovr_cnt); end
    ovr_clr = 1'b1; step(1); ovr_clr = 1'b0;
    checks++; if (ovr_cnt !== 8'd0) begin errors++; $display("FAIL ovr_clear: got %0d want 0", ovr_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_edge_latency();
    test_ack_mret();
    test_priority();
    test_gie();
    test_mask_and_async_reset();
`ifdef INTR_OVERRUN_CNT_EN
    test_overrun();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
